// File: rtl/mux_scan_ctrl_if.sv
// Purpose : groups the scan controller's request, leaf-mux drive and result signals.
// Latency : n/a (signal bundle only).
// Backpressure: none; start is a level request accepted only while the controller is idle.
//
// Signals:
//   start, abort  requester -> controller
//   bus_in        shared leaf-mux output line -> controller
//   en[3:0], s    controller -> leaf muxes (one-hot leaf enable, shared select)
//   data, busy, done  controller -> requester
interface mux_scan_ctrl_if;
  logic        start;
  logic        abort;
  logic        bus_in;
  logic [3:0]  en;
  logic [1:0]  s;
  logic [15:0] data;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, bus_in,
    input  en, s, data, busy, done
  );

  modport slave (
    input  start, abort, bus_in,
    output en, s, data, busy, done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Purpose : scans 16 channels through four 4:1 leaf muxes onto one shared line.
// Latency : done and data update 16*(SETTLE+1) edges after the start-sampling edge.
// Backpressure: start is ignored (not queued) while busy or in DONE; abort cancels a scan.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_scan_ctrl_if.slave: start/abort/bus_in in; en/s/data/busy/done out
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  en_q, en_d;
  logic [1:0]  s_q, s_d;
  logic [15:0] data_q, data_d;
  logic [15:0] shadow_q, shadow_d;

  // Leaf wiring: within a leaf, channel 0..3 sits on select 10, 11, 01, 00.
  function automatic logic [1:0] sel_enc(input logic [1:0] ch);
    logic [1:0] r;
    r = 2'b00;
    case (ch)
      2'd0: r = 2'b10;
      2'd1: r = 2'b11;
      2'd2: r = 2'b01;
      2'd3: r = 2'b00;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    en_d     = 4'b0000;
    s_d      = 2'b00;

    case (state_q)
      IDLE: begin
        // start together with abort is treated as no request.
        if (bus.start && !bus.abort) begin
          state_d = DRIVE;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        // Abort wins over the final sample so data is never half-updated.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          shadow_d[idx_q] = bus.bus_in;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            // Publish including the bit captured on this same edge.
            data_d  = shadow_d;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = 4'd0;
            state_d = DRIVE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Drive outputs are registered from the next state so they change on
    // the same edge the channel changes and then hold steady.
    if (state_d == DRIVE || state_d == SAMPLE) begin
      en_d = 4'b0001 << idx_d[3:2];
      s_d  = sel_enc(idx_d[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      cnt_q    <= 4'd0;
      en_q     <= 4'b0000;
      s_q      <= 2'b00;
      data_q   <= 16'h0000;
      shadow_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      s_q      <= s_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.en   = en_q;
  assign bus.s    = s_q;
  assign bus.data = data_q;
  assign bus.busy = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of wait cycles between driving a select and sampling the bus (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: requests one 16-channel scan.
REQ-005 The block SHALL have port abort, input, 1 bit: terminates a scan in progress.
REQ-006 The block SHALL have port bus_in, input, 1 bit: the shared tri-state line driven by four downstream 4:1 leaf muxes.
REQ-007 The block SHALL have port en, output, 4 bits: one-hot leaf enables, where en[k] enables leaf k.
REQ-008 The block SHALL have port s, output, 2 bits: the select shared by all leaves.
REQ-009 The block SHALL have port data, output, 16 bits: the last completed scan, where bit n is channel n.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.

Function
REQ-012 The block SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 In IDLE, start=1 SHALL set channel index idx=0, clear the settle counter and move to DRIVE; start=0 SHALL hold IDLE.
REQ-014 In DRIVE, the settle counter SHALL increment each cycle, and the state SHALL move to SAMPLE after SETTLE cycles in DRIVE.
REQ-015 SAMPLE SHALL last one cycle and write bus_in into shadow[idx] at its closing edge; if idx<15 it SHALL increment idx, clear the counter and return to DRIVE, and if idx==15 it SHALL move to DONE.
REQ-016 DONE SHALL last one cycle with done=1, copy shadow into data at its entering edge, and then return to IDLE.
REQ-017 In DRIVE and SAMPLE, en SHALL equal the one-hot decode of idx[3:2]; in IDLE and DONE, en SHALL be 4'b0000 so that the bus floats.
REQ-018 s SHALL encode idx[1:0] to match the leaf mapping: idx[1:0]=0 -> s=2'b10, 1 -> 2'b11, 2 -> 2'b01, 3 -> 2'b00; s SHALL be 2'b00 in IDLE and DONE.
REQ-019 en and s SHALL be registered outputs that stay stable throughout DRIVE and SAMPLE for a given idx.
REQ-020 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-021 Latency: with the start-sampling edge counted as edge 0, data SHALL update and done SHALL rise at edge 16*(SETTLE+1) (32 for SETTLE=1), and done SHALL fall at the next edge.
REQ-022 start asserted while busy=1 or in DONE SHALL be ignored and not queued.
REQ-023 abort=1 while busy=1 SHALL force IDLE at the next edge, with en=0, s=0, data unchanged and no done pulse.
REQ-024 abort SHALL take priority over a simultaneous SAMPLE-to-DONE transition, so that no data update occurs.
REQ-025 abort in IDLE or DONE SHALL have no effect, and a DONE cycle SHALL complete normally.
REQ-026 If start and abort are both high in IDLE, the block SHALL remain in IDLE.
REQ-027 bus_in SHALL be sampled only in SAMPLE; its value in all other states SHALL be ignored.
REQ-028 idx SHALL be 4 bits and SHALL never wrap past 15 within a scan.
REQ-029 The settle counter SHALL be 4 bits.

Reset
REQ-030 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, idx=0, counter=0, en=4'b0000, s=2'b00, data=16'h0000, shadow=16'h0000, busy=0 and done=0.
REQ-031 Reset asserted mid-scan SHALL discard the scan with no done pulse, and the first start accepted after rst_n rises SHALL begin at channel 0.

Verification
REQ-032 Reset test: assert rst_n=0 asynchronously between clock edges -> en=0, s=0, data=16'h0000, busy=0 and done=0 before the next edge.
REQ-033 Full-scan test: with SETTLE=1 and a behavioural model of four leaves holding pattern 16'hA5C3, pulse start -> done at edge 32, data=16'hA5C3, and en/s sequence 0001/10, 0001/11, 0001/01, 0001/00, 0010/10, ... through 1000/00.
REQ-034 Busy-start test: pulse start again at edge 5 of a scan -> no restart and done still at edge 32; then scan 16'h1234 -> data=16'h1234.
REQ-035 Abort test: after a completed scan of 16'hA5C3, start a scan of 16'hFFFF and assert abort while idx=7 -> next edge en=0, busy=0, data remains 16'hA5C3 and no done pulse.
REQ-036 Abort-at-last-sample test: assert abort during SAMPLE of idx=15 -> no done pulse and data unchanged.
REQ-037 Settle test: with SETTLE=3 -> done at edge 64, and each en/s value held 4 cycles before its sample.
